// File: rtl/prach_dec_pack.sv
// prach_dec_pack: polyphase packer between two half-band decimator stages.
// Pairs consecutive samples of each TDM channel into even/odd phases
// (dp1 = earlier, dp2 = later). The pairing phase and the held even sample
// are kept per channel, and one global flag remembers a pending frame sync.
module prach_dec_pack #(
  parameter int NUM_CHN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0][15:0] din_dq,
  input  logic             din_dv,
  input  logic [7:0]       din_chn,
  input  logic             sync_in,
  output logic [1:0][15:0] dout_dp1,
  output logic [1:0][15:0] dout_dp2,
  output logic             dout_dv,
  output logic [7:0]       dout_chn,
  output logic             sync_out
);

  localparam int CW = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;

  // Per-channel pairing state plus the global pending-sync flag.
  logic [NUM_CHN-1:0]       phase_q, phase_d;
  logic [NUM_CHN-1:0][31:0] hold_q, hold_d;
  logic                     sync_pend_q, sync_pend_d;

  // Registered output stage.
  logic [31:0] dp1_q, dp1_d;
  logic [31:0] dp2_q, dp2_d;
  logic        dv_q, dv_d;
  logic [7:0]  chn_q, chn_d;
  logic        sync_out_q, sync_out_d;

  logic          legal_s;
  logic [CW-1:0] idx_s;

  // Channel tags at or above NUM_CHN are dropped; the compare is done one bit
  // wider so that NUM_CHN = 256 still accepts every 8-bit tag.
  assign legal_s = din_dv && ({1'b0, din_chn} < 9'(NUM_CHN));
  assign idx_s   = din_chn[CW-1:0];

  // Next-state: sync clears all phases and takes priority over completing a
  // pair; otherwise an accepted sample either fills the hold or emits a pair.
  always_comb begin
    phase_d     = phase_q;
    hold_d      = hold_q;
    sync_pend_d = sync_pend_q;
    dp1_d       = dp1_q;
    dp2_d       = dp2_q;
    chn_d       = chn_q;
    dv_d        = 1'b0;
    sync_out_d  = 1'b0;
    if (sync_in) begin
      phase_d     = '0;
      sync_pend_d = 1'b1;
      if (legal_s) begin
        hold_d[idx_s]  = din_dq;
        phase_d[idx_s] = 1'b1;
      end else begin
        hold_d = hold_q;
      end
    end else if (legal_s) begin
      if (!phase_q[idx_s]) begin
        hold_d[idx_s]  = din_dq;
        phase_d[idx_s] = 1'b1;
      end else begin
        dp1_d          = hold_q[idx_s];
        dp2_d          = din_dq;
        chn_d          = din_chn;
        dv_d           = 1'b1;
        sync_out_d     = sync_pend_q;
        sync_pend_d    = 1'b0;
        phase_d[idx_s] = 1'b0;
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // State and output registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      hold_q      <= '0;
      sync_pend_q <= 1'b0;
      dp1_q       <= 32'd0;
      dp2_q       <= 32'd0;
      chn_q       <= 8'd0;
      dv_q        <= 1'b0;
      sync_out_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      sync_pend_q <= sync_pend_d;
      dp1_q       <= dp1_d;
      dp2_q       <= dp2_d;
      chn_q       <= chn_d;
      dv_q        <= dv_d;
      sync_out_q  <= sync_out_d;
    end
  end

  assign dout_dp1 = dp1_q;
  assign dout_dp2 = dp2_q;
  assign dout_dv  = dv_q;
  assign dout_chn = chn_q;
  assign sync_out = sync_out_q;

endmodule

// File: tb/tb_prach_dec_pack.sv
// Self-checking bench for prach_dec_pack: a reference model pushes expected
// pairs to a scoreboard queue as stimulus is driven; a monitor pops and
// compares them when the DUT emits a pair. Directed checks cover the
// scenarios of the test plan, followed by a random TDM run.
module tb_prach_dec_pack;

  localparam int NCH = 8;

  typedef struct {
    logic [7:0]  chn;
    logic [31:0] p1;
    logic [31:0] p2;
    logic        sy;
    int          cyc;
  } pair_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0][15:0] din_dq = '0;
  logic             din_dv = 1'b0;
  logic [7:0]       din_chn = 8'd0;
  logic             sync_in = 1'b0;
  logic [1:0][15:0] dout_dp1, dout_dp2;
  logic             dout_dv;
  logic [7:0]       dout_chn;
  logic             sync_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int npairs = 0;
  int nsync = 0;

  pair_t exp_q[$];
  pair_t mon_p;

  // model state
  logic        m_phase[NCH];
  logic [31:0] m_hold[NCH];
  logic        m_pend;

  prach_dec_pack #(.NUM_CHN(NCH)) dut (
    .clk(clk), .rst_n(rst_n),
    .din_dq(din_dq), .din_dv(din_dv), .din_chn(din_chn), .sync_in(sync_in),
    .dout_dp1(dout_dp1), .dout_dp2(dout_dp2), .dout_dv(dout_dv),
    .dout_chn(dout_chn), .sync_out(sync_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_phase[c] = 1'b0;
      m_hold[c]  = 32'd0;
    end
    m_pend = 1'b0;
  endtask

  // Drive one input cycle and update the reference model.
  task automatic send(input int chn, input logic [15:0] i, input logic [15:0] q,
                      input bit sy, input bit dv = 1'b1);
    logic [31:0] d;
    bit legal;
    pair_t p;
    d = {q, i};
    legal = dv && (chn < NCH);
    if (sy) begin
      for (int c = 0; c < NCH; c++) m_phase[c] = 1'b0;
      m_pend = 1'b1;
      if (legal) begin
        m_hold[chn]  = d;
        m_phase[chn] = 1'b1;
      end
    end else if (legal) begin
      if (!m_phase[chn]) begin
        m_hold[chn]  = d;
        m_phase[chn] = 1'b1;
      end else begin
        p.chn = 8'(chn);
        p.p1  = m_hold[chn];
        p.p2  = d;
        p.sy  = m_pend;
        p.cyc = cyc + 1;
        exp_q.push_back(p);
        m_pend       = 1'b0;
        m_phase[chn] = 1'b0;
      end
    end
    din_dq  = d;
    din_dv  = dv;
    din_chn = 8'(chn);
    sync_in = sy;
    @(posedge clk);
    #1;
    din_dv  = 1'b0;
    sync_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_dv"}, 64'(dout_dv), 64'd0);
    chk({tag, "_sync"}, 64'(sync_out), 64'd0);
    chk({tag, "_chn"}, 64'(dout_chn), 64'd0);
    chk({tag, "_dp1"}, 64'(dout_dp1), 64'd0);
    chk({tag, "_dp2"}, 64'(dout_dp2), 64'd0);
  endtask

  // Monitor: compare each emitted pair against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_dv) begin
        npairs++;
        if (sync_out) nsync++;
        if (exp_q.size() == 0) begin
          chk("spurious_pair", 64'd1, 64'd0);
        end else begin
          mon_p = exp_q.pop_front();
          chk("pair_chn", 64'(dout_chn), 64'(mon_p.chn));
          chk("pair_dp1", 64'(dout_dp1), 64'(mon_p.p1));
          chk("pair_dp2", 64'(dout_dp2), 64'(mon_p.p2));
          chk("pair_sync", 64'(sync_out), 64'(mon_p.sy));
          chk("pair_latency", 64'(cyc), 64'(mon_p.cyc));
        end
      end else begin
        chk("sync_without_dv", 64'(sync_out), 64'd0);
      end
    end
  end

  initial begin
    int n0;
    int s0;
    model_reset();
    #2;
    chk_outs_zero("reset");
    idle(2);
    rst_n = 1'b1;

    // Single channel: two pairs on chn 0.
    n0 = npairs;
    send(0, 16'd1, 16'd2, 1'b0);
    send(0, 16'd3, 16'd4, 1'b0);
    send(0, 16'd5, 16'd6, 1'b0);
    send(0, 16'd7, 16'd8, 1'b0);
    idle(2);
    chk("t1_pairs", 64'(npairs - n0), 64'd2);
    chk("t1_dp1", 64'(dout_dp1), 64'h0006_0005);
    chk("t1_dp2", 64'(dout_dp2), 64'h0008_0007);

    // Interleaved TDM channels 0,1,2.
    n0 = npairs;
    for (int k = 0; k < 6; k++) send(k % 3, 16'(10 + k), 16'(16'hFF00 + k), 1'b0);
    idle(2);
    chk("t2_pairs", 64'(npairs - n0), 64'd3);
    chk("t2_chn", 64'(dout_chn), 64'd2);
    chk("t2_dp1", 64'(dout_dp1), 64'hFF02_000C);
    chk("t2_dp2", 64'(dout_dp2), 64'hFF05_000F);

    // Sync in the middle of a pair on chn 3.
    n0 = npairs; s0 = nsync;
    send(3, 16'd100, 16'd0, 1'b0);
    send(3, 16'd200, 16'd0, 1'b1);
    send(3, 16'd300, 16'd0, 1'b0);
    idle(2);
    chk("t3_pairs", 64'(npairs - n0), 64'd1);
    chk("t3_sync", 64'(nsync - s0), 64'd1);
    chk("t3_dp1", 64'(dout_dp1), 64'd200);
    chk("t3_dp2", 64'(dout_dp2), 64'd300);
    send(3, 16'd400, 16'd0, 1'b0);
    send(3, 16'd500, 16'd0, 1'b0);
    idle(2);
    chk("t3_next_sync", 64'(nsync - s0), 64'd1);

    // Illegal channel with sync: dropped sample, phases still cleared.
    n0 = npairs; s0 = nsync;
    send(1, 16'd7, 16'd7, 1'b0);
    send(NCH, 16'd99, 16'd99, 1'b1);
    idle(2);
    chk("t4_no_pair", 64'(npairs - n0), 64'd0);
    send(1, 16'd20, 16'd0, 1'b0);
    send(1, 16'd21, 16'd0, 1'b0);
    idle(2);
    chk("t4_pairs", 64'(npairs - n0), 64'd1);
    chk("t4_sync", 64'(nsync - s0), 64'd1);
    chk("t4_dp1", 64'(dout_dp1), 64'd20);

    // Sync collides with pair completion.
    n0 = npairs; s0 = nsync;
    send(0, 16'hAAAA, 16'd1, 1'b0);
    send(0, 16'hBBBB, 16'd2, 1'b1);
    idle(2);
    chk("t5_no_pair", 64'(npairs - n0), 64'd0);
    send(0, 16'hCCCC, 16'd3, 1'b0);
    idle(2);
    chk("t5_pairs", 64'(npairs - n0), 64'd1);
    chk("t5_sync", 64'(nsync - s0), 64'd1);
    chk("t5_dp1", 64'(dout_dp1), 64'h0002_BBBB);
    chk("t5_dp2", 64'(dout_dp2), 64'h0003_CCCC);

    // Reset after an even sample on chn 5.
    send(5, 16'h5555, 16'h0505, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk_outs_zero("midreset");
    idle(1);
    rst_n = 1'b1;
    n0 = npairs;
    send(5, 16'h1234, 16'h4321, 1'b0);
    send(5, 16'h5678, 16'h8765, 1'b0);
    idle(2);
    chk("t6_pairs", 64'(npairs - n0), 64'd1);
    chk("t6_chn", 64'(dout_chn), 64'd5);
    chk("t6_dp1", 64'(dout_dp1), 64'h4321_1234);
    chk("t6_dp2", 64'(dout_dp2), 64'h8765_5678);

    // Random TDM traffic including illegal tags, idle cycles and syncs.
    for (int k = 0; k < 400; k++) begin
      send(int'($urandom_range(NCH, 0)), 16'($urandom), 16'($urandom),
           ($urandom_range(15, 0) == 0), ($urandom_range(7, 0) != 0));
    end
    idle(3);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
